// File: rtl/frame_hdr_parse.sv
// frame_hdr_parse
// Hunts a 32-bit word stream for a sync word, captures the following size
// word, announces it to the downstream payload counter (size_valid/size/
// data_start) and forwards the payload with a two-stage pipeline so that
// out_last lines up with the counter's own last flag. A gap inside the
// payload aborts the frame with a one-cycle err pulse.
module frame_hdr_parse #(
  parameter logic [31:0] SYNC_WORD = 32'hA5A5_5A5A,
  parameter logic [31:0] MAX_LEN   = 32'd1024
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        size_valid,
  output logic [31:0] size,
  output logic        data_start,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        err,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_SIZE    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] size_q, size_d;
  logic        size_valid_q, size_valid_d;
  logic        data_start_q, data_start_d;
  logic        err_q, err_d;

  // Word accepted as payload this cycle, and whether it is the final one.
  logic        acc_s;
  logic        acc_last_s;

  // First payload pipeline stage (word accepted one cycle ago).
  logic        s1_valid_q;
  logic        s1_last_q;
  logic [31:0] s1_data_q;

  // Output stage (word accepted two cycles ago).
  logic        out_valid_q;
  logic        out_last_q;
  logic [31:0] out_data_q;

  logic [15:0] frame_cnt_q;

  // Next-state, size capture and event decode for the header FSM.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    size_d       = size_q;
    size_valid_d = 1'b0;
    data_start_d = 1'b0;
    err_d        = 1'b0;
    acc_s        = 1'b0;
    acc_last_s   = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (in_valid && (in_data == SYNC_WORD)) begin
          state_d = ST_SIZE;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_SIZE: begin
        if (in_valid) begin
          // Unsigned compare: huge values (top bit set) are rejected too.
          if ((in_data == 32'd0) || (in_data > MAX_LEN)) begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end else begin
            remaining_d  = in_data;
            size_valid_d = 1'b1;
            size_d       = in_data - 32'd1;
            state_d      = ST_WAIT;
          end
        end else begin
          state_d = ST_SIZE;
        end
      end
      ST_WAIT: begin
        if (in_valid) begin
          acc_s        = 1'b1;
          data_start_d = 1'b1;
          remaining_d  = remaining_q - 32'd1;
          if (remaining_q == 32'd1) begin
            acc_last_s = 1'b1;
            state_d    = ST_HUNT;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_PAYLOAD: begin
        if (in_valid) begin
          acc_s       = 1'b1;
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) begin
            acc_last_s = 1'b1;
            state_d    = ST_HUNT;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end else begin
          // Downstream counter decrements every cycle, so a gap is fatal.
          err_d       = 1'b1;
          remaining_d = 32'd0;
          state_d     = ST_HUNT;
        end
      end
      default: begin
        state_d     = ST_HUNT;
        remaining_d = 32'd0;
      end
    endcase
  end

  // FSM state, header outputs and frame counter registers.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      remaining_q  <= 32'd0;
      size_q       <= 32'd0;
      size_valid_q <= 1'b0;
      data_start_q <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      size_q       <= size_d;
      size_valid_q <= size_valid_d;
      data_start_q <= data_start_d;
      err_q        <= err_d;
      if (acc_s && acc_last_s) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Two-stage payload pipeline; aborted frames still drain what was accepted.
  always_ff @(posedge clock) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_data_q   <= 32'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 32'd0;
    end else begin
      s1_valid_q  <= acc_s;
      s1_last_q   <= acc_s & acc_last_s;
      if (acc_s) begin
        s1_data_q <= in_data;
      end
      out_valid_q <= s1_valid_q;
      out_last_q  <= s1_valid_q & s1_last_q;
      out_data_q  <= s1_data_q;
    end
  end

  assign size_valid = size_valid_q;
  assign size       = size_q;
  assign data_start = data_start_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign err        = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_frame_hdr_parse.sv
// Scoreboard bench for frame_hdr_parse: every driven word pushes the events
// it must cause (with the cycle they must appear in); the per-cycle monitor
// pops and compares them against the DUT outputs.
module tb_frame_hdr_parse;

  localparam logic [31:0] SYNC = 32'hA5A5_5A5A;
  localparam logic [31:0] MAXL = 32'd1024;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        size_valid;
  logic [31:0] size;
  logic        data_start;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        err;
  logic [15:0] frame_cnt;

  frame_hdr_parse #(.SYNC_WORD(SYNC), .MAX_LEN(MAXL)) dut (
    .clock(clock), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .size_valid(size_valid), .size(size), .data_start(data_start),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_out_q[$];
  exp_t        exp_size_q[$];
  int          exp_ds_q[$];
  int          exp_err_q[$];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fails = 0;
  logic [15:0] exp_cnt = 16'd0;
  logic [31:0] exp_size = 32'd0;
  int          rem = 0;
  bit          first = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: cycle %0d got 0x%08h expected 0x%08h", tag, cyc, obs, exp);
    end
  endtask

  // Compares all outputs for the current cycle against the scoreboard.
  task automatic monitor();
    exp_t e;
    bit   ev;
    ev = (exp_out_q.size() > 0) && (exp_out_q[0].cyc == cyc);
    check_val("out_valid", {31'd0, out_valid}, {31'd0, ev});
    if (ev) begin
      e = exp_out_q.pop_front();
      check_val("out_data", out_data, e.data);
      check_val("out_last", {31'd0, out_last}, {31'd0, e.last});
    end else begin
      check_val("out_last_idle", {31'd0, out_last}, 32'd0);
    end
    ev = (exp_size_q.size() > 0) && (exp_size_q[0].cyc == cyc);
    check_val("size_valid", {31'd0, size_valid}, {31'd0, ev});
    if (ev) begin
      e = exp_size_q.pop_front();
      exp_size = e.data;
    end
    check_val("size", size, exp_size);
    ev = (exp_ds_q.size() > 0) && (exp_ds_q[0] == cyc);
    check_val("data_start", {31'd0, data_start}, {31'd0, ev});
    if (ev) begin
      void'(exp_ds_q.pop_front());
    end
    ev = (exp_err_q.size() > 0) && (exp_err_q[0] == cyc);
    check_val("err", {31'd0, err}, {31'd0, ev});
    if (ev) begin
      void'(exp_err_q.pop_front());
    end
    check_val("frame_cnt", {16'd0, frame_cnt}, {16'd0, exp_cnt});
  endtask

  // Drives one cycle of input, then checks the outputs of the next cycle.
  task automatic step(input logic v, input logic [31:0] d, input logic r);
    rst      = r;
    in_valid = v;
    in_data  = d;
    if (r) begin
      exp_out_q.delete();
      exp_size_q.delete();
      exp_ds_q.delete();
      exp_err_q.delete();
      exp_cnt  = 16'd0;
      exp_size = 32'd0;
      rem      = 0;
      first    = 1'b0;
    end
    @(posedge clock);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic t_sync();
    step(1'b1, SYNC, 1'b0);
  endtask

  // Non-sync word while hunting (top nibble never matches SYNC).
  task automatic t_junk(input logic [31:0] d);
    step(1'b1, d & 32'h0FFF_FFFF, 1'b0);
  endtask

  task automatic t_size(input logic [31:0] n);
    exp_t e;
    if ((n == 32'd0) || (n > MAXL)) begin
      exp_err_q.push_back(cyc + 1);
    end else begin
      e.cyc  = cyc + 1;
      e.data = n - 32'd1;
      e.last = 1'b0;
      exp_size_q.push_back(e);
      rem   = int'(n);
      first = 1'b1;
    end
    step(1'b1, n, 1'b0);
  endtask

  task automatic t_pay(input logic [31:0] d);
    exp_t e;
    e.cyc  = cyc + 2;
    e.data = d;
    e.last = (rem == 1);
    exp_out_q.push_back(e);
    if (first) begin
      exp_ds_q.push_back(cyc + 1);
    end
    first = 1'b0;
    rem--;
    if (rem == 0) begin
      exp_cnt = exp_cnt + 16'd1;
    end
    step(1'b1, d, 1'b0);
  endtask

  task automatic t_idle();
    if ((rem > 0) && !first) begin
      exp_err_q.push_back(cyc + 1);
      rem = 0;
    end
    step(1'b0, $urandom, 1'b0);
  endtask

  task automatic t_rst();
    step(1'($urandom_range(0, 1)), $urandom, 1'b1);
  endtask

  initial begin
    // Reset with random inputs, then junk must produce nothing.
    t_rst();
    t_rst();
    for (int i = 0; i < 4; i++) t_junk($urandom);

    // Basic N=3 frame.
    t_junk(32'h0000_1234);
    t_sync();
    t_size(32'd3);
    t_pay(32'hD000_0000);
    t_pay(32'hD111_1111);
    t_pay(32'hD222_2222);

    // N=1 with idle cycles everywhere they are legal.
    t_idle();
    t_sync();
    t_idle();
    t_idle();
    t_size(32'd1);
    t_idle();
    t_idle();
    t_pay(32'hCAFE_F00D);
    t_idle();

    // Illegal sizes, including a sync pattern as size, then a good N=2 frame.
    t_sync();
    t_size(32'd0);
    t_sync();
    t_size(MAXL + 32'd1);
    t_sync();
    t_size(32'hFFFF_FFFF);
    t_sync();
    t_size(SYNC);
    t_sync();
    t_size(32'd2);
    t_pay(32'h1111_0001);
    t_pay(32'h1111_0002);

    // Gap mid-payload aborts; an immediately following frame completes.
    t_sync();
    t_size(32'd4);
    t_pay(32'h4444_0001);
    t_pay(32'h4444_0002);
    t_idle();
    t_sync();
    t_size(32'd2);
    t_pay(32'h0000_000A);
    t_pay(32'h0000_000B);

    // SYNC right after a final word; SYNC values as payload data.
    t_sync();
    t_size(32'd3);
    t_pay(SYNC);
    t_pay(32'h5555_0002);
    t_pay(SYNC);

    // Reset in the middle of an N=8 payload, then a fresh frame.
    t_sync();
    t_size(32'd8);
    t_pay(32'h8888_0001);
    t_pay(32'h8888_0002);
    t_pay(32'h8888_0003);
    t_rst();
    t_sync();
    t_size(32'd2);
    t_pay(32'h2222_0001);
    t_pay(32'h2222_0002);

    // Largest legal frame.
    t_idle();
    t_sync();
    t_size(MAXL);
    for (int i = 0; i < int'(MAXL); i++) t_pay(32'h7000_0000 + 32'(i * 3));

    // Drain and make sure every expected event was seen.
    for (int i = 0; i < 4; i++) t_idle();
    check_val("sb_empty",
              32'(exp_out_q.size() + exp_size_q.size() + exp_ds_q.size() + exp_err_q.size()),
              32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
